// File: rtl/uart_trx_if.sv
// -----------------------------------------------------------------------------
// uart_trx_if
//   Byte-side handshake bundle of the uart_trx UART.
//
//   Transmit port (valid/ready):
//     tx_data       byte to send, sampled on accept (tx_valid & tx_ready)
//     tx_valid      transmit request
//     tx_ready      UART can accept a byte (TX idle)
//     tx_busy       a frame is being shifted out
//   Receive port (valid/ready):
//     rx_data       received byte, stable while rx_valid is high
//     rx_valid      received byte available
//     rx_ready      consumer pop (rx_valid & rx_ready)
//     rx_frame_err  one-cycle pulse: stop bit sampled low
//     rx_overrun    one-cycle pulse: a completed byte was dropped
//
//   master : the SoC-side user of the UART
//   slave  : the UART itself
// -----------------------------------------------------------------------------
interface uart_trx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_busy, rx_data, rx_valid, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_trx.sv
// -----------------------------------------------------------------------------
// uart_trx
//   Full-duplex 8N1 UART. Serializes bytes from a valid/ready transmit port
//   onto ser_tx and deserializes ser_rx into a buffered valid/ready receive
//   port. Framing errors and overruns are reported as one-cycle pulses.
//   Bit time is CLKS_PER_BIT clock cycles (4166 gives 9600 baud at 40 MHz;
//   legal range 4..65535).
//
//   Ports:
//     wb_clk_i   system clock, all logic on the rising edge
//     wb_rst_i   asynchronous, active-high reset
//     ser_rx     serial input, idle high, asynchronous to wb_clk_i
//     ser_tx     serial output, idle high, registered
//     bus        uart_trx_if.slave byte-side handshake (see uart_trx_if.sv)
//
//   Build option:
//     UART_TRX_RX_FIFO_EN  defined   -> 4-entry receive FIFO
//                          undefined -> single-entry receive buffer
// -----------------------------------------------------------------------------
module uart_trx #(
  parameter int unsigned CLKS_PER_BIT = 4166
) (
  input  logic      wb_clk_i,
  input  logic      wb_rst_i,
  input  logic      ser_rx,
  output logic      ser_tx,
  uart_trx_if.slave bus
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] BIT_HALF = 16'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_t   tx_state, tx_state_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx, tx_idx_next;
  logic [7:0]  tx_shift;
  logic        tx_accept;
  logic        tx_bit_done;
  logic        ser_tx_next;

  assign tx_accept   = bus.tx_valid && (tx_state == TX_IDLE);
  assign tx_bit_done = (tx_cnt == BIT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    tx_state_next = tx_state;
    tx_idx_next   = tx_idx;
    ser_tx_next   = 1'b1;

    case (tx_state)
      TX_IDLE:  if (tx_accept)   tx_state_next = TX_START;
      TX_START: if (tx_bit_done) tx_state_next = TX_DATA;
      TX_DATA: begin
        if (tx_bit_done) begin
          tx_idx_next = tx_idx + 3'd1;  // wraps 7 -> 0 when leaving DATA
          if (tx_idx == 3'd7) tx_state_next = TX_STOP;
        end
      end
      TX_STOP:  if (tx_bit_done) tx_state_next = TX_IDLE;
      default:  tx_state_next = TX_IDLE;
    endcase

    // The line level is decided from the state being entered so that ser_tx
    // can be a flop and still change on the same edge as the state.
    case (tx_state_next)
      TX_START: ser_tx_next = 1'b0;
      TX_DATA:  ser_tx_next = tx_shift[tx_idx_next];
      default:  ser_tx_next = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      ser_tx   <= 1'b1;
    end else begin
      tx_state <= tx_state_next;
      tx_idx   <= tx_idx_next;
      ser_tx   <= ser_tx_next;
      if (tx_accept) tx_shift <= bus.tx_data;
      if ((tx_state == TX_IDLE) || tx_bit_done) tx_cnt <= '0;
      else                                      tx_cnt <= tx_cnt + 16'd1;
    end
  end

  assign bus.tx_ready = (tx_state == TX_IDLE);
  assign bus.tx_busy  = (tx_state != TX_IDLE);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  // Two-flop synchronizer, preset to the idle level so reset release does not
  // look like a start bit.
  logic [1:0] rx_sync;
  logic       rxs;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], ser_rx};
  end

  assign rxs = rx_sync[1];

  rx_state_t   rx_state, rx_state_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift;
  logic        rx_half;
  logic        rx_bit_done;
  logic        rx_sample;
  logic        rx_push;
  logic        rx_ferr_next;

  assign rx_half     = (rx_cnt == BIT_HALF);
  assign rx_bit_done = (rx_cnt == BIT_LAST);

  always_comb begin
    rx_state_next = rx_state;
    rx_sample     = 1'b0;
    rx_push       = 1'b0;
    rx_ferr_next  = 1'b0;

    case (rx_state)
      RX_IDLE:  if (!rxs) rx_state_next = RX_START;
      // Mid start bit: a line that is already back high was only a glitch.
      RX_START: if (rx_half) rx_state_next = rxs ? RX_IDLE : RX_DATA;
      // The counter restarted at mid start bit, so bit_done lands mid-bit.
      RX_DATA: begin
        if (rx_bit_done) begin
          rx_sample = 1'b1;
          if (rx_idx == 3'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_done) begin
          if (rxs) begin
            rx_push       = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            rx_ferr_next  = 1'b1;
            rx_state_next = RX_BREAK;
          end
        end
      end
      // A held-low line produces one error, not one per frame time.
      RX_BREAK: if (rxs) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_state         <= RX_IDLE;
      rx_cnt           <= '0;
      rx_idx           <= '0;
      rx_shift         <= '0;
      bus.rx_frame_err <= 1'b0;
    end else begin
      rx_state         <= rx_state_next;
      bus.rx_frame_err <= rx_ferr_next;
      if ((rx_state == RX_IDLE) || (rx_state == RX_BREAK) ||
          (rx_state_next != rx_state) || rx_bit_done)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 16'd1;
      if (rx_sample) begin
        rx_shift <= {rxs, rx_shift[7:1]};  // LSB arrives first
        rx_idx   <= rx_idx + 3'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive buffer
  // ---------------------------------------------------------------------------
`ifdef UART_TRX_RX_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       fifo_pop;
  logic       fifo_wr;

  assign fifo_full = (fifo_count == 3'd4);
  assign fifo_pop  = (fifo_count != 3'd0) && bus.rx_ready;
  // A pop in the same cycle frees the slot the write goes into.
  assign fifo_wr   = rx_push && (!fifo_full || fifo_pop);

  // NOTE: the storage is reset along with the pointers because rx_data is
  // read straight from it and must come out of reset as 0x00.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_count     <= '0;
      bus.rx_overrun <= 1'b0;
    end else begin
      bus.rx_overrun <= rx_push && fifo_full && !fifo_pop;
      if (fifo_wr) begin
        fifo_mem[wr_ptr] <= rx_shift;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + 3'(fifo_wr) - 3'(fifo_pop);
    end
  end

  assign bus.rx_valid = (fifo_count != 3'd0);
  assign bus.rx_data  = fifo_mem[rd_ptr];
`else
  logic [7:0] rx_buf;
  logic       rx_full;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_buf         <= '0;
      rx_full        <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else begin
      // An occupied, unpopped buffer keeps the old byte; the new one is lost.
      bus.rx_overrun <= rx_push && rx_full && !bus.rx_ready;
      if (rx_push && (!rx_full || bus.rx_ready)) begin
        rx_buf  <= rx_shift;
        rx_full <= 1'b1;
      end else if (rx_full && bus.rx_ready) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign bus.rx_valid = rx_full;
  assign bus.rx_data  = rx_buf;
`endif

endmodule

// File: doc/uart_trx.md
# uart_trx

Synthesizable full-duplex 8N1 UART for the SoC side of the serial link; it is the counterpart of the external UART display model used on the testbench. It serializes bytes from a valid/ready transmit port onto `ser_tx` and deserializes `ser_rx` into a buffered valid/ready receive port. It reports framing errors and overruns as single-cycle pulses. Bit timing is an integer clock divider; the default gives 9600 baud from a 40 MHz clock.

## Interface
- `CLKS_PER_BIT`, 4166, clock cycles per serial bit; legal range 4..65535; 16-bit counters.
- `wb_clk_i`  in  1  system clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `ser_rx`  in  1  serial input, idle high, asynchronous to `wb_clk_i`.
- `ser_tx`  out  1  serial output, idle high, registered.
- `tx_data`  in  8  byte to send; sampled on accept.
- `tx_valid`  in  1  transmit request.
- `tx_ready`  out  1  high only in TX IDLE; accept = `tx_valid & tx_ready`.
- `tx_busy`  out  1  high from the cycle after accept through the end of the stop bit.
- `rx_data`  out  8  received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1  received byte available.
- `rx_ready`  in  1  consumer pop; pop = `rx_valid & rx_ready`.
- `rx_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `rx_overrun`  out  1  one-cycle pulse: a completed byte was dropped.

## Operation
- Reset values: `ser_tx`=1, `tx_ready`=1, `tx_busy`=0, `rx_valid`=0, `rx_data`=0x00, `rx_frame_err`=0, `rx_overrun`=0. Both FSMs go to IDLE, counters clear, and the synchronizer flops preset to 1.
- **TX FSM: IDLE → START → DATA → STOP → IDLE.**
  - IDLE: `ser_tx`=1. On accept, latch `tx_data` into the shift register and go to START.
  - START: `ser_tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, each held `CLKS_PER_BIT` cycles; a 3-bit index wraps 7→0 on exit.
  - STOP: `ser_tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
  - `tx_valid` is ignored outside IDLE.
- **RX input:** `ser_rx` passes through a 2-flop synchronizer before use. All RX decisions use the synchronized value `rxs`.
- **RX FSM: IDLE → START → DATA → STOP → IDLE, plus BREAK.**
  - IDLE: when `rxs`=0, go to START with counter=0.
  - START: at count `CLKS_PER_BIT/2` (floor), sample `rxs`. If 0, go to DATA. If 1, it was a glitch; return to IDLE without error.
  - DATA: sample every `CLKS_PER_BIT` cycles (mid-bit). Shift in LSB first, 8 samples.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - 1: push the byte and return to IDLE.
    - 0: pulse `rx_frame_err`, discard the byte, go to BREAK.
  - BREAK: stay until `rxs`=1, then IDLE. A held-low line yields exactly one error.
- **RX buffer (default):** one entry.
  - A push while the entry is empty or being popped in the same cycle stores the byte and sets `rx_valid`.
  - A push while `rx_valid` is high and `rx_ready` is low keeps the old byte, drops the new one, and pulses `rx_overrun`.
- TX and RX operate fully independently; simultaneous activity is required to work.

## Timing
- TX accept at cycle T: `ser_tx` falls at T+1. The frame occupies T+1..T+10·`CLKS_PER_BIT`. `tx_ready` is high again at T+10·`CLKS_PER_BIT`+1. The minimum inter-frame idle is one cycle.
- RX: the synchronized falling edge is seen 2–3 cycles after the line falls. The stop sample occurs floor(`CLKS_PER_BIT`/2)+9·`CLKS_PER_BIT` cycles after the FSM enters START. `rx_valid` rises the following cycle.
- `rx_valid` deasserts the cycle after a pop, unless another entry is present.
- `rx_frame_err` and `rx_overrun` are exactly one cycle wide.
- Reset mid-frame: outputs take their reset values immediately (asynchronously). The partial TX and RX bytes are lost, and no error pulses occur.

## Configuration
- `UART_TRX_RX_FIFO_EN`
  - **Defined:** the RX buffer is a 4-entry FIFO with 2-bit wrapping pointers and a 3-bit count.
    - `rx_data` shows the head entry.
    - `rx_overrun` fires only on a push while full with no same-cycle pop.
    - A push and pop in the same cycle when full succeeds, and the count stays 4.
  - **Undefined:** the single-entry buffer described above.

## Test plan
- Use `CLKS_PER_BIT`=16 throughout.
- TX: accept 0xA5 → `ser_tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each 16 cycles. `tx_ready` is low for 160 cycles, `tx_busy` matches.
- RX: bit-accurate driver sends 0x3C → one `rx_valid` with `rx_data`=0x3C, no error pulses. Byte is held until `rx_ready`=1.
- Loopback `ser_tx`→`ser_rx`: back-to-back 0x00, 0xFF, 0x55 with `rx_ready`=1 → the same three bytes are received in order with no errors.
- Framing: send 0x12 with the stop bit low and hold the line low 40 cycles → one `rx_frame_err` pulse and no `rx_valid`. A following 0x34 is received correctly.
- Overrun: `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and one `rx_overrun` pulse occurs. With `UART_TRX_RX_FIFO_EN`, send 0x01..0x05 → 0x01..0x04 pop in order and overrun fires on 0x05.
- Glitch/reset: `ser_rx` low for 4 cycles → no reception. Assert `wb_rst_i` mid-TX data bit → `ser_tx`=1 and `tx_ready`=1 immediately; a new 0x5A sends cleanly after release.
